except_commit_ctrl: RTL and testbench

//  Commit-stage exception/interrupt controller; sits directly upstream of cp0.

---
 rtl/except_commit_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_except_commit_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/except_commit_ctrl.sv
// Commit-stage exception/interrupt controller: merges ROB-head exceptions with interrupts, drives cp0, flush and fetch redirect.
// Optional CPU_EXT_INT_SYNC_EN: 2-flop synchroniser on ext_int ahead of the interrupt logic.
package except_commit_pkg;
  typedef struct packed {
    logic       bev;
    logic [7:0] im;
    logic       erl;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic [7:0] ip;
  } cp0_cause_t;

  typedef struct packed {
    cp0_status_t status;
    cp0_cause_t  cause;
    logic [31:0] epc;
    logic [31:0] error_epc;
    logic [31:0] ebase;
  } cp0_regs_t;

  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        delayslot;
    logic [31:0] extra;
  } except_req_t;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
endpackage

module except_commit_ctrl
  import except_commit_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter logic [31:0] BEV_VECTOR = 32'hBFC00200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  head_valid,
  input  logic [31:0]           head_pc,
  input  logic                  head_delayslot,
  input  logic                  head_ex_valid,
  input  logic [4:0]            head_ex_code,
  input  logic [31:0]           head_ex_extra,
  input  logic                  head_tlb_refill,
  input  logic                  head_eret,
  input  logic [HW_INT_NUM-1:0] ext_int,
  input  logic                  timer_int,
  input  cp0_regs_t             regs,
  input  logic                  sb_empty,
  output logic                  commit_stall,
  output except_req_t           except_req,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  typedef enum logic [1:0] {IDLE, FIRE, DRAIN, REDIR} state_t;
  state_t state, state_nxt;

  logic [HW_INT_NUM-1:0] ext_src;
  logic [HW_INT_NUM-1:0] hw_ip;
  logic                  int_pending;
  logic                  int_take;
  logic                  ev_take;

  logic        ev_eret_p1;
  logic [4:0]  ev_code_p1;
  logic [31:0] ev_pc_p1;
  logic        ev_ds_p1;
  logic [31:0] ev_extra_p1;
  logic        ev_refill_p1;
  logic [31:0] redir_pc_p2;

  logic unused_regs;
  assign unused_regs = ^{regs.cause.ip[7:2], regs.ebase[11:0], regs.status.im[1:0]};

`ifdef CPU_EXT_INT_SYNC_EN
  logic [HW_INT_NUM-1:0] ext_meta;
  logic [HW_INT_NUM-1:0] ext_sync;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_meta <= '0;
      ext_sync <= '0;
    end else begin
      ext_meta <= ext_int;
      ext_sync <= ext_meta;
    end
  end
  assign ext_src = ext_sync;
`else
  assign ext_src = ext_int;
`endif

  // Timer shares the top hardware line, as cause.ip[7] does on cp0.
  assign hw_ip       = ext_src | {timer_int, {(HW_INT_NUM-1){1'b0}}};
  assign int_pending = (|(hw_ip & regs.status.im[HW_INT_NUM+1:2])) & regs.status.ie &
                       ~regs.status.exl & ~regs.status.erl;
  assign int_take    = int_pending & ~head_delayslot;
  assign ev_take     = head_valid & (int_take | head_ex_valid | head_eret);

  function automatic logic [31:0] redirect_target(input logic eret, input logic [4:0] code,
                                                  input logic refill, input cp0_regs_t r);
    logic [31:0] base;
    logic        is_refill;
    base      = r.status.bev ? BEV_VECTOR : {r.ebase[31:12], 12'h000};
    is_refill = ((code == EXC_TLBL) || (code == EXC_TLBS)) && refill && !r.status.exl;
    if (eret)
      return r.status.erl ? r.error_epc : r.epc;
    return is_refill ? base : base + 32'h0000_0180;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev_take) state_nxt = FIRE;
      FIRE:    state_nxt = DRAIN;
      DRAIN:   if (sb_empty) state_nxt = REDIR;
      REDIR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p1: event captured at the head; p2: redirect target sampled in FIRE before cp0 updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_eret_p1   <= 1'b0;
      ev_code_p1   <= '0;
      ev_pc_p1     <= '0;
      ev_ds_p1     <= 1'b0;
      ev_extra_p1  <= '0;
      ev_refill_p1 <= 1'b0;
      redir_pc_p2  <= '0;
    end else begin
      if (state == IDLE && ev_take) begin
        ev_eret_p1   <= ~int_take & ~head_ex_valid & head_eret;
        ev_code_p1   <= int_take ? EXC_INT : (head_ex_valid ? head_ex_code : EXC_INT);
        ev_pc_p1     <= head_pc;
        ev_ds_p1     <= head_delayslot;
        ev_extra_p1  <= int_take ? {{(30-HW_INT_NUM){1'b0}}, hw_ip, regs.cause.ip[1:0]}
                                 : head_ex_extra;
        ev_refill_p1 <= ~int_take & head_tlb_refill;
      end
      if (state == FIRE)
        redir_pc_p2 <= redirect_target(ev_eret_p1, ev_code_p1, ev_refill_p1, regs);
    end
  end

  always_comb begin
    except_req     = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    commit_stall   = (state != IDLE) | ev_take;
    if (state == FIRE) begin
      except_req.valid     = 1'b1;
      except_req.eret      = ev_eret_p1;
      except_req.code      = ev_code_p1;
      except_req.pc        = ev_pc_p1;
      except_req.delayslot = ev_ds_p1;
      except_req.extra     = ev_extra_p1;
      flush                = 1'b1;
    end
    if (state == REDIR) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_pc_p2;
    end
  end

endmodule

// File: tb/tb_except_commit_ctrl.sv
// Directed bench for except_commit_ctrl: exceptions, TLB refill, ERET, interrupts, drain stall and mid-sequence reset.
module tb_except_commit_ctrl;
  import except_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        head_valid, head_delayslot, head_ex_valid, head_tlb_refill, head_eret;
  logic [31:0] head_pc, head_ex_extra;
  logic [4:0]  head_ex_code;
  logic [5:0]  ext_int;
  logic        timer_int;
  cp0_regs_t   regs;
  logic        sb_empty;
  logic        commit_stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  except_req_t except_req;

  int n_vec = 0;
  int n_err = 0;

  except_req_t req;
  logic        fl;
  logic [31:0] rpc;
  int          lat;

  always #5 clk = ~clk;

  except_commit_ctrl #(.HW_INT_NUM(6), .BEV_VECTOR(32'hBFC00200)) dut (
    .clk(clk), .rst_n(rst_n),
    .head_valid(head_valid), .head_pc(head_pc), .head_delayslot(head_delayslot),
    .head_ex_valid(head_ex_valid), .head_ex_code(head_ex_code), .head_ex_extra(head_ex_extra),
    .head_tlb_refill(head_tlb_refill), .head_eret(head_eret),
    .ext_int(ext_int), .timer_int(timer_int), .regs(regs), .sb_empty(sb_empty),
    .commit_stall(commit_stall), .except_req(except_req), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_head;
    head_valid      = 1'b0;
    head_delayslot  = 1'b0;
    head_ex_valid   = 1'b0;
    head_ex_code    = 5'h00;
    head_ex_extra   = 32'h0;
    head_tlb_refill = 1'b0;
    head_eret       = 1'b0;
    head_pc         = 32'h0;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [4:0] code,
                        input logic [31:0] extra, input logic refill);
    head_valid      = 1'b1;
    head_pc         = pc;
    head_ex_valid   = 1'b1;
    head_ex_code    = code;
    head_ex_extra   = extra;
    head_tlb_refill = refill;
  endtask

  // Head inputs are already presented in an IDLE cycle; returns the FIRE-cycle request and the redirect.
  task automatic run_event(input string tag, output except_req_t r, output logic f,
                           output logic [31:0] p, output int l);
    #1;
    chk({tag, ".stall"}, 32'(commit_stall), 32'd1);
    tick;
    r = except_req;
    f = flush;
    clear_head();
    l = 1;
    p = 32'h0;
    for (int i = 0; i < 30; i++) begin
      tick;
      l++;
      if (redirect_valid) begin
        p = redirect_pc;
        break;
      end
    end
    tick;
  endtask

  initial begin
    clear_head();
    rst_n     = 1'b0;
    ext_int   = '0;
    timer_int = 1'b0;
    sb_empty  = 1'b1;
    regs      = '0;
    regs.ebase = 32'h8000_0000;
    regs.epc   = 32'h8000_2000;
    regs.error_epc = 32'hBFC0_0000;
    tick; tick;
    chk("rst.valid", 32'(except_req.valid), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.redir", 32'(redirect_valid), 32'd0);
    chk("rst.rpc",   redirect_pc, 32'h0);
    rst_n = 1'b1;
    tick;
    chk("idle.stall", 32'(commit_stall), 32'd0);

    set_ex(32'h8000_1000, 5'h04, 32'h13, 1'b0);
    run_event("adel", req, fl, rpc, lat);
    chk("adel.valid", 32'(req.valid), 32'd1);
    chk("adel.code",  32'(req.code), 32'd4);
    chk("adel.extra", req.extra, 32'h13);
    chk("adel.pc",    req.pc, 32'h8000_1000);
    chk("adel.eret",  32'(req.eret), 32'd0);
    chk("adel.flush", 32'(fl), 32'd1);
    chk("adel.rpc",   rpc, 32'h8000_0180);
    chk("adel.lat",   32'(lat), 32'd3);
    chk("adel.after_stall", 32'(commit_stall), 32'd0);
    chk("adel.after_redir", 32'(redirect_valid), 32'd0);

    set_ex(32'h8000_1100, 5'h02, 32'h4000_0000, 1'b1);
    run_event("tlbl_ref", req, fl, rpc, lat);
    chk("tlbl_ref.code", 32'(req.code), 32'd2);
    chk("tlbl_ref.rpc",  rpc, 32'h8000_0000);
    regs.status.exl = 1'b1;
    set_ex(32'h8000_1104, 5'h02, 32'h4000_0000, 1'b1);
    run_event("tlbl_exl", req, fl, rpc, lat);
    chk("tlbl_exl.rpc", rpc, 32'h8000_0180);
    regs.status.exl = 1'b0;
    set_ex(32'h8000_1108, 5'h03, 32'h4000_0010, 1'b0);
    run_event("tlbs_inv", req, fl, rpc, lat);
    chk("tlbs_inv.rpc", rpc, 32'h8000_0180);
    regs.status.bev = 1'b1;
    set_ex(32'h8000_110C, 5'h04, 32'h1, 1'b0);
    run_event("bev", req, fl, rpc, lat);
    chk("bev.rpc", rpc, 32'hBFC0_0380);
    regs.status.bev = 1'b0;

    head_valid = 1'b1; head_pc = 32'h8000_1200; head_eret = 1'b1;
    run_event("eret", req, fl, rpc, lat);
    chk("eret.eret", 32'(req.eret), 32'd1);
    chk("eret.rpc",  rpc, 32'h8000_2000);
    regs.status.erl = 1'b1;
    head_valid = 1'b1; head_pc = 32'h8000_1204; head_eret = 1'b1;
    run_event("eret_erl", req, fl, rpc, lat);
    chk("eret_erl.rpc", rpc, 32'hBFC0_0000);
    regs.status.erl = 1'b0;
    head_valid = 1'b1; head_eret = 1'b1;
    set_ex(32'h8000_1208, 5'h0A, 32'h0, 1'b0);
    run_event("ex_over_eret", req, fl, rpc, lat);
    chk("ex_over_eret.eret", 32'(req.eret), 32'd0);
    chk("ex_over_eret.code", 32'(req.code), 32'd10);

    regs.status.im = 8'h10;
    regs.status.ie = 1'b1;
    ext_int = 6'b000100;
    head_valid = 1'b1; head_pc = 32'h8000_1300; head_delayslot = 1'b1;
    #1;
    chk("int_ds.stall0", 32'(commit_stall), 32'd0);
    tick; tick; tick;
    chk("int_ds.stall3", 32'(commit_stall), 32'd0);
    head_delayslot = 1'b0; head_pc = 32'h8000_1304;
    run_event("int", req, fl, rpc, lat);
    chk("int.code",  32'(req.code), 32'd0);
    chk("int.extra", req.extra, 32'h10);
    chk("int.pc",    req.pc, 32'h8000_1304);
    chk("int.rpc",   rpc, 32'h8000_0180);
    set_ex(32'h8000_1308, 5'h04, 32'h55, 1'b0);
    run_event("int_over_ex", req, fl, rpc, lat);
    chk("int_over_ex.code", 32'(req.code), 32'd0);
    set_ex(32'h8000_130C, 5'h04, 32'h55, 1'b0);
    head_delayslot = 1'b1;
    run_event("ds_ex", req, fl, rpc, lat);
    chk("ds_ex.code", 32'(req.code), 32'd4);
    chk("ds_ex.ds",   32'(req.delayslot), 32'd1);
    ext_int = '0;
    regs.status.ie = 1'b0;
    tick; tick; tick;

    sb_empty = 1'b0;
    set_ex(32'h8000_1400, 5'h05, 32'h77, 1'b0);
    #1;
    tick;
    clear_head();
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("drain.stall", 32'(commit_stall), 32'd1);
      chk("drain.redir", 32'(redirect_valid), 32'd0);
      tick;
    end
    sb_empty = 1'b1;
    #1;
    chk("drain.redir_rise", 32'(redirect_valid), 32'd0);
    tick;
    chk("drain.redir_v", 32'(redirect_valid), 32'd1);
    chk("drain.rpc",     redirect_pc, 32'h8000_0180);
    tick;

    sb_empty = 1'b0;
    set_ex(32'h8000_1500, 5'h04, 32'h0, 1'b0);
    #1;
    tick;
    clear_head();
    tick;
    rst_n = 1'b0;
    tick;
    chk("abort.stall", 32'(commit_stall), 32'd0);
    chk("abort.flush", 32'(flush), 32'd0);
    chk("abort.valid", 32'(except_req.valid), 32'd0);
    chk("abort.redir", 32'(redirect_valid), 32'd0);
    chk("abort.rpc",   redirect_pc, 32'h0);
    rst_n    = 1'b1;
    sb_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abort.no_redir", 32'(redirect_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
